congestion_monitor: RTL and testbench
=====================================

CONGESTION_MONITOR -- requirements
Module: congestion_monitor

Interface
REQ-001 The block SHALL have parameter WINDOW_CYCLES, default 1024, giving the number of sampled cycles per measurement window; legal range 1 to 2**CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of each event counter.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start_i, input, 1 bit: request to begin a measurement window.
REQ-006 The block SHALL have port valid_i, input, 1 bit: passive tap of the observed stream's valid.
REQ-007 The block SHALL have port ready_i, input, 1 bit: passive tap of the observed stream's ready.
REQ-008 The block SHALL have port busy_o, output, 1 bit: high in MEASURE and DIVIDE.
REQ-009 The block SHALL have port done_o, output, 1 bit: high while results are valid, in DONE.
REQ-010 The block SHALL have port xfer_cnt_o, output, CNT_W bits: count of cycles with valid_i & ready_i.
REQ-011 The block SHALL have port stall_cnt_o, output, CNT_W bits: count of cycles with valid_i & ~ready_i.
REQ-012 The block SHALL have port idle_cnt_o, output, CNT_W bits: count of cycles with ~valid_i.
REQ-013 The block SHALL have port congestion_pct_o, output, 7 bits: measured congestion, 0..100.
REQ-014 The block SHALL have port violation_o, output, 1 bit: sticky valid-stability violation flag.

Function
REQ-015 The block SHALL implement the FSM states IDLE, MEASURE, DIVIDE and DONE.
REQ-016 When start_i is sampled high in IDLE or DONE, the block SHALL clear all counters, congestion_pct_o and violation_o and enter MEASURE on the next cycle.
REQ-017 The block SHALL ignore start_i in MEASURE and DIVIDE.
REQ-018 MEASURE SHALL last exactly WINDOW_CYCLES cycles, and each MEASURE cycle SHALL increment exactly one of xfer, stall or idle.
REQ-019 At the end of the window, xfer_cnt_o + stall_cnt_o + idle_cnt_o SHALL equal WINDOW_CYCLES.
REQ-020 After the last MEASURE cycle, the block SHALL enter DIVIDE and compute congestion_pct_o = floor(stall*100 / (stall+xfer)) with a 7-iteration restoring divider, one quotient bit per cycle, MSB first.
REQ-021 DIVIDE SHALL last exactly 7 cycles, after which the block SHALL enter DONE.
REQ-022 If stall+xfer = 0, congestion_pct_o SHALL be 0 and DIVIDE SHALL still last 7 cycles.
REQ-023 Intermediate divider state SHALL use CNT_W+8 bits so that stall*100 does not overflow.
REQ-024 congestion_pct_o SHALL update only on entry to DONE and SHALL hold its value until the next start_i is accepted.
REQ-025 All counter outputs SHALL be live during MEASURE and SHALL hold their values in DIVIDE and DONE.
REQ-026 The block SHALL NOT drive or affect valid_i or ready_i.

Reset
REQ-027 When rst_ni is sampled low, the next state SHALL be IDLE with all counters, congestion_pct_o, violation_o, done_o, busy_o and the divider registers at 0.
REQ-028 Reset asserted mid-MEASURE or mid-DIVIDE SHALL abort the measurement with no partial result retained.

Configuration
REQ-029 The feature macro SHALL be CONGESTION_MONITOR_PROTOCOL_CHECK_EN.
REQ-030 With CONGESTION_MONITOR_PROTOCOL_CHECK_EN defined, during MEASURE a cycle with valid_i=1 and ready_i=0 followed by a cycle with valid_i=0 SHALL set violation_o on the next cycle.
REQ-031 Once set, violation_o SHALL remain high until reset or an accepted start_i.
REQ-032 Without CONGESTION_MONITOR_PROTOCOL_CHECK_EN, violation_o SHALL be constant 0 and no check logic SHALL be present.

Verification
REQ-033 Scenario: W=16, valid_i=ready_i=1 throughout -> xfer=16, stall=0, idle=0, pct=0; done_o rises exactly 1+16+7 cycles after start_i is sampled.
REQ-034 Scenario: W=16, valid_i=1, ready_i high every 4th cycle -> xfer=4, stall=12, idle=0, pct=75.
REQ-035 Scenario: W=16, valid_i=0 throughout -> idle=16, pct=0 through the zero-denominator path.
REQ-036 Scenario: W=7, stall=3 and xfer=4 -> pct=42, which checks floor rounding.
REQ-037 Scenario: valid_i=1/ready_i=0, then valid_i=0 -> violation_o=1 and sticky with the macro defined; violation_o=0 with it undefined.
REQ-038 Scenario: rst_ni low at MEASURE cycle 5 -> IDLE with all outputs 0; start_i pulsed in MEASURE -> ignored, window length unchanged.

Source files
------------

// File: rtl/congestion_monitor_if.sv
// Congestion monitor bus: measurement start request, passive tap of the
// observed stream's valid/ready pair, and the measurement results.
// master = environment side, slave = the monitor.
interface congestion_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start_i;
    logic             valid_i;
    logic             ready_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] xfer_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] idle_cnt_o;
    logic [6:0]       congestion_pct_o;
    logic             violation_o;

    modport master (
        output start_i,
        output valid_i,
        output ready_i,
        input  busy_o,
        input  done_o,
        input  xfer_cnt_o,
        input  stall_cnt_o,
        input  idle_cnt_o,
        input  congestion_pct_o,
        input  violation_o
    );

    modport slave (
        input  start_i,
        input  valid_i,
        input  ready_i,
        output busy_o,
        output done_o,
        output xfer_cnt_o,
        output stall_cnt_o,
        output idle_cnt_o,
        output congestion_pct_o,
        output violation_o
    );
endinterface

// File: rtl/congestion_monitor.sv
// Congestion monitor: passively classifies each cycle of a fixed window as
// transfer, stall or idle, then computes stall*100/(stall+xfer) with a
// 7-step restoring divider. FSM: IDLE -> MEASURE -> DIVIDE -> DONE.
// Optional valid-stability check (sticky violation_o) is compiled in only
// when CONGESTION_MONITOR_PROTOCOL_CHECK_EN is defined; otherwise
// violation_o is tied to 0.
module congestion_monitor #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    congestion_monitor_if.slave mon
);

    // Dividend stall*100 needs 7 extra bits; one more keeps the compare safe.
    localparam int unsigned      DIV_W      = CNT_W + 8;
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [2:0]       LAST_STEP  = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE,
        DONE
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] xfer_q,  stall_q,  idle_q;
    logic [CNT_W-1:0] xfer_d,  stall_d,  idle_d;
    logic [DIV_W-1:0] rem_q,   rem_d;
    logic [DIV_W-1:0] dvs_q;
    logic [6:0]       quot_q,  quot_d;
    logic [6:0]       pct_q;
    logic [2:0]       step_q;
    logic             busy_q,  done_q;
    logic             start_acc;
    logic             take;

    // A start request is honoured only while no measurement is running.
    assign start_acc = mon.start_i && ((state_q == IDLE) || (state_q == DONE));

    // Classify the current cycle: exactly one counter advances.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        xfer_d  = xfer_q;
        stall_d = stall_q;
        idle_d  = idle_q;
        if (!mon.valid_i) begin
            idle_d = idle_q + CNT_W'(1);
        end else if (mon.ready_i) begin
            xfer_d = xfer_q + CNT_W'(1);
        end else begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // One restoring-division step; a zero divisor never subtracts, so the
    // empty-window case yields a zero quotient over the same 7 steps.
    always_comb begin
        take   = (dvs_q != '0) && (rem_q >= dvs_q);
        rem_d  = take ? (rem_q - dvs_q) : rem_q;
        quot_d = {quot_q[5:0], take};
    end

    // Main FSM with registered busy/done and result holding.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_ni) begin
            // NOTE: divider and result registers are reset too, so an aborted run leaves nothing behind.
            state_q <= IDLE;
            win_q   <= '0;
            xfer_q  <= '0;
            stall_q <= '0;
            idle_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            step_q  <= '0;
            pct_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_acc) begin
                        state_q <= MEASURE;
                        win_q   <= '0;
                        xfer_q  <= '0;
                        stall_q <= '0;
                        idle_q  <= '0;
                        rem_q   <= '0;
                        dvs_q   <= '0;
                        quot_q  <= '0;
                        step_q  <= '0;
                        pct_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                MEASURE: begin
                    xfer_q  <= xfer_d;
                    stall_q <= stall_d;
                    idle_q  <= idle_d;
                    win_q   <= win_q + CNT_W'(1);
                    if (win_q == LAST_CYCLE) begin
                        // Load the divider from the final counts, divisor
                        // pre-aligned to quotient bit 6.
                        state_q <= DIVIDE;
                        rem_q   <= DIV_W'(stall_d) * DIV_W'(100);
                        dvs_q   <= (DIV_W'(stall_d) + DIV_W'(xfer_d)) << 6;
                        quot_q  <= '0;
                        step_q  <= '0;
                    end
                end
                DIVIDE: begin
                    rem_q  <= rem_d;
                    dvs_q  <= dvs_q >> 1;
                    quot_q <= quot_d;
                    step_q <= step_q + 3'd1;
                    if (step_q == LAST_STEP) begin
                        state_q <= DONE;
                        pct_q   <= quot_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mon.busy_o           = busy_q;
    assign mon.done_o           = done_q;
    assign mon.xfer_cnt_o       = xfer_q;
    assign mon.stall_cnt_o      = stall_q;
    assign mon.idle_cnt_o       = idle_q;
    assign mon.congestion_pct_o = pct_q;

`ifdef CONGESTION_MONITOR_PROTOCOL_CHECK_EN
    logic prev_stall_q;
    logic viol_q;

    // Flag valid dropping right after a stalled cycle inside the window;
    // sticky until reset or the next accepted start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_stall_q <= 1'b0;
            viol_q       <= 1'b0;
        end else if (start_acc) begin
            prev_stall_q <= 1'b0;
            viol_q       <= 1'b0;
        end else if (state_q == MEASURE) begin
            prev_stall_q <= mon.valid_i && !mon.ready_i;
            if (prev_stall_q && !mon.valid_i) begin
                viol_q <= 1'b1;
            end
        end else begin
            prev_stall_q <= 1'b0;
        end
    end

    assign mon.violation_o = viol_q;
`else
    assign mon.violation_o = 1'b0;
`endif

endmodule

// File: tb/tb_congestion_monitor.sv
// Self-checking bench for congestion_monitor: a 16-cycle and a 7-cycle
// instance share the observed valid/ready taps; expected window results
// go into a scoreboard queue as stimulus is driven and are popped when
// done_o rises.
module tb_congestion_monitor;

    localparam int CNT_W = 32;

    typedef struct {
        int xfer;
        int stall;
        int idle;
        int pct;
        bit viol;
    } exp_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start16 = 1'b0;
    logic start7  = 1'b0;
    logic valid   = 1'b0;
    logic ready   = 1'b0;
    logic sel7    = 1'b0;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    congestion_monitor_if #(.CNT_W(CNT_W)) if16 ();
    congestion_monitor_if #(.CNT_W(CNT_W)) if7 ();

    assign if16.start_i = start16;
    assign if16.valid_i = valid;
    assign if16.ready_i = ready;
    assign if7.start_i  = start7;
    assign if7.valid_i  = valid;
    assign if7.ready_i  = ready;

    congestion_monitor #(.WINDOW_CYCLES(16), .CNT_W(CNT_W)) dut16 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .mon    (if16)
    );

    congestion_monitor #(.WINDOW_CYCLES(7), .CNT_W(CNT_W)) dut7 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .mon    (if7)
    );

    logic [CNT_W-1:0] m_xfer, m_stall, m_idle;
    logic [6:0]       m_pct;
    logic             m_busy, m_done, m_viol;

    assign m_xfer  = sel7 ? if7.xfer_cnt_o       : if16.xfer_cnt_o;
    assign m_stall = sel7 ? if7.stall_cnt_o      : if16.stall_cnt_o;
    assign m_idle  = sel7 ? if7.idle_cnt_o       : if16.idle_cnt_o;
    assign m_pct   = sel7 ? if7.congestion_pct_o : if16.congestion_pct_o;
    assign m_busy  = sel7 ? if7.busy_o           : if16.busy_o;
    assign m_done  = sel7 ? if7.done_o           : if16.done_o;
    assign m_viol  = sel7 ? if7.violation_o      : if16.violation_o;

    // One full window: mode picks the valid/ready pattern, poke_start pulses
    // start_i mid-window (must be ignored).
    task automatic run_window(input string name, input bit use7, input int w,
                              input int mode, input bit poke_start);
        int   ex, es, ei, cyc;
        bit   v, r, prev_stall, ev;
        exp_t e;
        sel7 = use7;
        @(negedge clk);
        valid = 1'b0;
        ready = 1'b0;
        if (use7) start7 = 1'b1; else start16 = 1'b1;
        @(negedge clk);
        start7 = 1'b0;
        start16 = 1'b0;
        ex = 0; es = 0; ei = 0; prev_stall = 1'b0; ev = 1'b0;
        for (int i = 0; i < w; i++) begin
            case (mode)
                0:       begin v = 1'b1;     r = 1'b1;         end
                1:       begin v = 1'b1;     r = (i % 4 == 3); end
                2:       begin v = 1'b0;     r = i[0];         end
                3:       begin v = 1'b1;     r = (i >= 3);     end
                4:       begin v = (i != 1); r = (i >= 2);     end
                default: begin
                    v = 1'($urandom_range(0, 1));
                    r = 1'($urandom_range(0, 1));
                end
            endcase
            valid = v;
            ready = r;
            if (poke_start && i == 5) begin
                if (use7) start7 = 1'b1; else start16 = 1'b1;
            end else begin
                start7 = 1'b0;
                start16 = 1'b0;
            end
            if (!v) ei++;
            else if (r) ex++;
            else es++;
`ifdef CONGESTION_MONITOR_PROTOCOL_CHECK_EN
            if (prev_stall && !v) ev = 1'b1;
`endif
            prev_stall = v && !r;
            @(negedge clk);
            tests_run++;
            if (m_xfer !== CNT_W'(ex) || m_stall !== CNT_W'(es) || m_idle !== CNT_W'(ei) ||
                m_pct !== 7'd0 || m_viol !== ev || m_busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s live c%0d: got x=%0d s=%0d i=%0d pct=%0d viol=%0b busy=%0b, need x=%0d s=%0d i=%0d pct=0 viol=%0b busy=1",
                         name, i, m_xfer, m_stall, m_idle, m_pct, m_viol, m_busy, ex, es, ei, ev);
            end
        end
        e.xfer  = ex;
        e.stall = es;
        e.idle  = ei;
        e.pct   = (ex + es == 0) ? 0 : (es * 100) / (ex + es);
        e.viol  = ev;
        sb.push_back(e);
        valid = 1'b0;
        ready = 1'b0;
        start7 = 1'b0;
        start16 = 1'b0;

        cyc = w + 1;
        while (m_done !== 1'b1 && cyc < w + 60) begin
            tests_run++;
            if (m_xfer !== CNT_W'(ex) || m_stall !== CNT_W'(es) || m_idle !== CNT_W'(ei) ||
                m_pct !== 7'd0 || m_busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s divide_hold c%0d: got x=%0d s=%0d i=%0d pct=%0d busy=%0b, need x=%0d s=%0d i=%0d pct=0 busy=1",
                         name, cyc, m_xfer, m_stall, m_idle, m_pct, m_busy, ex, es, ei);
            end
            @(negedge clk);
            cyc++;
        end

        tests_run++;
        if (m_done !== 1'b1 || cyc != 1 + w + 7) begin
            tests_failed++;
            $display("FAIL %s latency: done=%0b at cycle %0d, need done=1 at cycle %0d",
                     name, m_done, cyc, 1 + w + 7);
        end

        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s scoreboard: queue empty, need one entry", name);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if (m_xfer !== CNT_W'(e.xfer) || m_stall !== CNT_W'(e.stall) ||
                m_idle !== CNT_W'(e.idle) || m_pct !== 7'(e.pct) ||
                m_viol !== e.viol || m_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s result: got x=%0d s=%0d i=%0d pct=%0d viol=%0b busy=%0b, need x=%0d s=%0d i=%0d pct=%0d viol=%0b busy=0",
                         name, m_xfer, m_stall, m_idle, m_pct, m_viol, m_busy,
                         e.xfer, e.stall, e.idle, e.pct, e.viol);
            end
            repeat (3) @(negedge clk);
            tests_run++;
            if (m_done !== 1'b1 || m_pct !== 7'(e.pct) || m_xfer !== CNT_W'(e.xfer) ||
                m_viol !== e.viol) begin
                tests_failed++;
                $display("FAIL %s done_hold: got done=%0b pct=%0d x=%0d viol=%0b, need done=1 pct=%0d x=%0d viol=%0b",
                         name, m_done, m_pct, m_xfer, m_viol, e.pct, e.xfer, e.viol);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (if16.busy_o !== 1'b0 || if16.done_o !== 1'b0 || if16.xfer_cnt_o !== '0 ||
            if16.stall_cnt_o !== '0 || if16.idle_cnt_o !== '0 ||
            if16.congestion_pct_o !== 7'd0 || if16.violation_o !== 1'b0 ||
            if7.busy_o !== 1'b0 || if7.done_o !== 1'b0 || if7.congestion_pct_o !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%0b done=%0b x=%0d s=%0d i=%0d pct=%0d viol=%0b, need all 0",
                     if16.busy_o, if16.done_o, if16.xfer_cnt_o, if16.stall_cnt_o,
                     if16.idle_cnt_o, if16.congestion_pct_o, if16.violation_o);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (if16.busy_o !== 1'b0 || if16.done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%0b done=%0b, need 0 0", if16.busy_o, if16.done_o);
        end
    endtask

    task automatic test_all_xfer();
        run_window("all_xfer", 1'b0, 16, 0, 1'b0);
    endtask

    task automatic test_quarter_ready();
        run_window("quarter_ready", 1'b0, 16, 1, 1'b0);
    endtask

    task automatic test_all_idle();
        run_window("all_idle", 1'b0, 16, 2, 1'b0);
    endtask

    task automatic test_floor();
        run_window("floor_w7", 1'b1, 7, 3, 1'b0);
    endtask

    task automatic test_violation();
        run_window("violation", 1'b0, 16, 4, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_window("start_ignored", 1'b0, 16, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_window("b2b_rand_a", 1'b0, 16, 5, 1'b0);
        run_window("b2b_rand_b", 1'b0, 16, 5, 1'b1);
        run_window("b2b_rand_w7", 1'b1, 7, 5, 1'b0);
    endtask

    // Abort once in MEASURE (after 5 sampled cycles) and once in DIVIDE.
    task automatic test_reset_mid();
        int abort_at;
        sel7 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            abort_at = (k == 0) ? 5 : 19;
            @(negedge clk);
            start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            for (int i = 0; i < abort_at; i++) begin
                valid = (i != 1);
                ready = (i >= 2) && (i != 3);
                @(negedge clk);
            end
            valid = 1'b0;
            ready = 1'b0;
            tests_run++;
            if (m_busy !== 1'b1 || m_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_pre k%0d: got busy=%0b done=%0b, need 1 0", k, m_busy, m_done);
            end
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            tests_run++;
            if (m_busy !== 1'b0 || m_done !== 1'b0 || m_xfer !== '0 || m_stall !== '0 ||
                m_idle !== '0 || m_pct !== 7'd0 || m_viol !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid k%0d: got busy=%0b done=%0b x=%0d s=%0d i=%0d pct=%0d viol=%0b, need all 0",
                         k, m_busy, m_done, m_xfer, m_stall, m_idle, m_pct, m_viol);
            end
            repeat (30) @(negedge clk);
            tests_run++;
            if (m_busy !== 1'b0 || m_done !== 1'b0 || m_xfer !== '0 || m_pct !== 7'd0) begin
                tests_failed++;
                $display("FAIL reset_mid_no_result k%0d: got busy=%0b done=%0b x=%0d pct=%0d, need all 0",
                         k, m_busy, m_done, m_xfer, m_pct);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_xfer();
        test_quarter_ready();
        test_all_idle();
        test_floor();
        test_violation();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, need completion before 200000");
        $fatal(1);
    end

endmodule
